// File: rtl/prbs_pkg.sv
// prbs_pkg -- shared definitions for the SERDES test-pattern sequencer.
//   PRBS_W / DATA_W   : pattern register width and serializer word width
//   PRBS_SEED         : default generator reload value (bit k set for odd k)
//   PRBS_ALIGN_WORD   : default training/comma word
//   prbs_state_e      : sequencer FSM states
package prbs_pkg;

  localparam int PRBS_W = 127;
  localparam int DATA_W = 32;

  // 63 copies of "10" give bits 1,3,..,125 set; bit 126 (even) is clear.
  localparam logic [PRBS_W-1:0] PRBS_SEED       = {1'b0, {63{2'b10}}};
  localparam logic [DATA_W-1:0] PRBS_ALIGN_WORD = 32'hBCBC_BCBC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } prbs_state_e;

endpackage

// File: rtl/prbs_rot127.sv
// prbs_rot127 -- 127-bit rotating pattern register.
//   clk, rst_n : clock, synchronous active-low reset (reloads SEED)
//   load       : reload SEED (takes priority over advance)
//   advance    : rotate right by one word, new[k] = old[(k+32) mod 127]
//   word       : low DATA_W bits of the current pattern
module prbs_rot127
  import prbs_pkg::*;
#(
  parameter logic [PRBS_W-1:0] SEED = PRBS_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] word
);

  logic [PRBS_W-1:0] pat_q;

  always_ff @(posedge clk) begin
    if (!rst_n)       pat_q <= SEED;
    else if (load)    pat_q <= SEED;
    // Rotation by 32 on a 127-bit ring: the low word wraps to the top.
    else if (advance) pat_q <= {pat_q[DATA_W-1:0], pat_q[PRBS_W-1:DATA_W]};
  end

  assign word = pat_q[DATA_W-1:0];

endmodule

// File: rtl/prbs_burst_ctrl.sv
// prbs_burst_ctrl -- burst sequencer for the SERDES test-pattern path.
// Emits ALIGN_CNT alignment words, then burst_len pattern words (0 = until
// stop) from prbs_rot127, over a valid/ready handshake.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, stop         : one-cycle burst begin / early-end pulses
//   burst_len           : pattern words per burst, sampled with start
//   tx_ready            : serializer accepts the presented word
//   tx_valid/tx_data    : word to serializer; tx_is_align marks ALIGN_WORD
//   busy, done          : FSM not idle / one-cycle end-of-burst pulse
//   word_cnt            : pattern words accepted in current/last burst
//   err_inject          : only when PRBS_ERR_INJECT_EN is defined; arms a
//                         one-shot bit-0 flip of the next pattern word
// All outputs are decoded from registered state, so data follows the
// accepting edge by one cycle and stays stable while stalled.
module prbs_burst_ctrl
  import prbs_pkg::*;
#(
  parameter logic [PRBS_W-1:0] SEED       = PRBS_SEED,
  parameter logic [DATA_W-1:0] ALIGN_WORD = PRBS_ALIGN_WORD,
  parameter int                ALIGN_CNT  = 16,
  parameter int                BURST_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               tx_ready,
`ifdef PRBS_ERR_INJECT_EN
  input  logic               err_inject,
`endif
  output logic               tx_valid,
  output logic [DATA_W-1:0]  tx_data,
  output logic               tx_is_align,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] word_cnt
);

  localparam logic [15:0] ALIGN_LAST = 16'(ALIGN_CNT - 1);

  prbs_state_e        state_q, state_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [15:0]        acnt_q, acnt_d;
  logic               pend_q, pend_d;
  logic               gen_load, gen_adv;
  logic [DATA_W-1:0]  gen_word;
  logic               accept, stop_req, flip_w;

  prbs_rot127 #(.SEED(SEED)) u_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (gen_load),
    .advance (gen_adv),
    .word    (gen_word)
  );

  assign tx_valid = (state_q == ST_ALIGN) || (state_q == ST_RUN);
  assign accept   = tx_valid & tx_ready;
  // A stop arriving together with an accept ends on that accept.
  assign stop_req = stop | pend_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    acnt_d   = acnt_q;
    pend_d   = pend_q;
    gen_load = 1'b0;
    gen_adv  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_ALIGN;
        len_d    = burst_len;
        cnt_d    = '0;
        acnt_d   = '0;
        pend_d   = 1'b0;
        gen_load = 1'b1;
      end
      ST_ALIGN: begin
        if (accept) begin
          acnt_d = acnt_q + 16'd1;
          if (stop_req)                 state_d = ST_DONE;
          else if (acnt_q == ALIGN_LAST) state_d = ST_RUN;
        end else if (stop) begin
          pend_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          gen_adv = 1'b1;
          cnt_d   = cnt_q + BURST_W'(1);
          if (stop_req || (len_q != '0 && cnt_d == len_q)) state_d = ST_DONE;
        end else if (stop) begin
          pend_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acnt_q  <= acnt_d;
      pend_q  <= pend_d;
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  // armed_q waits for the next new pattern word; flip_q marks the word
  // currently presented as the corrupted one, so a stalled word stays stable.
  logic armed_q, flip_q, new_run_word;
  assign new_run_word = accept && (state_d == ST_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      flip_q  <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      armed_q <= 1'b0;
      flip_q  <= 1'b0;
    end else if (new_run_word) begin
      flip_q  <= armed_q | err_inject;
      armed_q <= 1'b0;
    end else if (err_inject) begin
      armed_q <= 1'b1;
    end
  end

  assign flip_w = flip_q & (state_q == ST_RUN);
`else
  assign flip_w = 1'b0;
`endif

  always_comb begin
    tx_data = '0;
    if (state_q == ST_ALIGN)    tx_data = ALIGN_WORD;
    else if (state_q == ST_RUN) tx_data = gen_word ^ {{(DATA_W-1){1'b0}}, flip_w};
  end

  assign tx_is_align = (state_q == ST_ALIGN);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign word_cnt    = cnt_q;

endmodule

// File: doc/prbs_burst_ctrl.md
# prbs_burst_ctrl

Sequencer for the 32-bit SERDES test-pattern path. On command it emits a programmable number of alignment words, then a burst of words from a 127-bit rotating pattern generator. Words go to the TX serializer over a valid/ready handshake. It sits between the link-test control registers and the serializer's parallel input, and replaces the free-running debug pattern source.

## Interface
Parameters:
- `SEED`, 127'h2AAA…AAA (alternating, bit k = 1 for odd k), generator reload value.
- `ALIGN_WORD`, 32'hBCBC_BCBC, training/comma word sent before the pattern.
- `ALIGN_CNT`, 16, number of alignment words per burst (≥1).
- `BURST_W`, 16, width of the burst length and word counter.

Ports:
- `clk`, in, 1, single clock for all logic.
- `rst_n`, in, 1, reset, **synchronous, active-low**.
- `start`, in, 1, one-cycle pulse that begins a burst.
- `stop`, in, 1, one-cycle pulse that ends a burst early.
- `burst_len`, in, BURST_W, pattern words per burst; 0 = continuous. Sampled on the start cycle.
- `tx_ready`, in, 1, serializer accepts the word this cycle.
- `tx_valid`, out, 1, `tx_data` is valid.
- `tx_data`, out, 32, word to the serializer.
- `tx_is_align`, out, 1, current word is `ALIGN_WORD`.
- `busy`, out, 1, FSM is not in IDLE.
- `done`, out, 1, one-cycle pulse when a burst ends.
- `word_cnt`, out, BURST_W, pattern words accepted in the current or last burst.
- `err_inject`, in, 1, present only with `PRBS_ERR_INJECT_EN`.

## Operation
- FSM states: IDLE, ALIGN, RUN, DONE.
- IDLE → ALIGN on `start`:
  - latch `burst_len`;
  - reload the generator with `SEED`;
  - clear `word_cnt` and the align counter.
- ALIGN:
  - `tx_data=ALIGN_WORD`, `tx_is_align=1`;
  - after `ALIGN_CNT` accepted words → RUN.
- RUN:
  - `tx_data` = generator low 32 bits;
  - each accepted word rotates the generator right by 32 (`new[k]=old[(k+32) mod 127]`) and increments `word_cnt`, which wraps;
  - after `burst_len` accepted words (len≠0) → DONE.
- DONE: `done=1` for one cycle, then → IDLE. `word_cnt` is held until the next `start`.
- Accepted word means `tx_valid & tx_ready`. The generator and counters advance only on an accepted word.
- `stop` in ALIGN/RUN:
  - it is registered as pending;
  - the FSM moves to DONE after the word currently presented is accepted;
  - if no word is presented, it moves to DONE on the next cycle.
- `start` while `busy` is ignored. `stop` in IDLE/DONE is ignored. `start` and `stop` in the same cycle in IDLE: start is honoured, stop is dropped.
- Sub-module: `prbs_rot127`, which holds the 127-bit pattern register and has load and advance inputs.

## Timing
- Reset values:
  - `tx_valid=0`, `tx_data=0`, `tx_is_align=0`;
  - `busy=0`, `done=0`, `word_cnt=0`;
  - FSM = IDLE, generator = `SEED`.
- Reset mid-burst: all of the above take effect on the next edge; no `done` pulse is produced.
- `start` at edge n:
  - `busy=1` and `tx_valid=1` with the first `ALIGN_WORD` from edge n+1;
  - zero bubble between words while `tx_ready=1`.
- ALIGN→RUN is gapless: the first pattern word is presented the cycle after the last align word is accepted.
- While `tx_valid & !tx_ready`, `tx_data` and `tx_is_align` are held stable. `tx_valid` does not drop before acceptance.
- Last pattern word accepted at edge m:
  - `tx_valid=0`, `busy=1`, `done=1` from m+1 to m+2;
  - `busy=0` from m+2.
- Throughput: 1 word/cycle. Output latency is 1 cycle from the accept that advances the state.

## Configuration
- `PRBS_ERR_INJECT_EN` defined:
  - the `err_inject` port exists;
  - a pulse arms a one-shot that inverts bit 0 of the next RUN word presented;
  - the generator state is not corrupted;
  - an arm while already armed is ignored;
  - the arm is cleared by `start` or reset.
- Not defined: the port is absent and data is never altered.

## Structure
- Shared package `prbs_pkg`:
  - FSM state enum;
  - `SEED` default constant;
  - `ALIGN_WORD` default;
  - `PRBS_W=127`, `DATA_W=32`.
- One sub-module, `prbs_rot127`, with inputs clk/rst_n/load/advance and output `word[31:0]`.
- The FSM, counters and output register live in `prbs_burst_ctrl`.

## Test plan
- Basic burst:
  - stimulus: `start`, `burst_len=4`, `ALIGN_CNT=16`, `tx_ready=1`;
  - response: 16×0xBCBCBCBC with `tx_is_align=1`, then 0xAAAAAAAA, 0xAAAAAAAA, 0xAAAAAAAA, 0x2AAAAAAA;
  - then `done` pulse, `word_cnt=4`.
- Backpressure:
  - stimulus: `tx_ready` low for 3 cycles in mid-RUN;
  - response: `tx_data` stable and `tx_valid` high throughout the stall; no word skipped or repeated.
- Early stop:
  - stimulus: `stop` in RUN after 2 accepted words, with `burst_len=0`;
  - response: the pending word completes, then `done`, `word_cnt=3` if a word was presented.
- Reset mid-burst:
  - stimulus: `rst_n=0` in ALIGN;
  - response: all outputs at reset values next edge, no `done`; the next `start` replays from the seed.
- Start while busy:
  - stimulus: `start` pulse during RUN;
  - response: ignored; burst length and data unchanged.
- With `PRBS_ERR_INJECT_EN`:
  - stimulus: `err_inject` before word 1;
  - response: word 1 = 0xAAAAAAAB, word 2 = 0xAAAAAAAA.
